// File: rtl/flight_cmd_pkg.sv
// Shared opcodes, response codes, FSM states and the opcode decoder used by the
// flight command configuration block.
package flight_cmd_pkg;

  localparam logic [7:0] OP_SET_CH0 = 8'h02;
  localparam logic [7:0] OP_SET_CH2 = 8'h04;
  localparam logic [7:0] OP_THRUST  = 8'h05;
  localparam logic [7:0] OP_CAL     = 8'h06;
  localparam logic [7:0] OP_ELAND   = 8'h07;
  localparam logic [7:0] OP_MOFF    = 8'h08;
  localparam logic [7:0] OP_WD_EN   = 8'h09;
  localparam logic [3:0] OP_CH_NIB  = 4'h1;

  localparam logic [7:0] RESP_ACK   = 8'hA5;
  localparam logic [7:0] RESP_NAK   = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EXEC, ST_RESP, ST_SPINUP, ST_CAL
  } state_e;

  typedef enum logic [2:0] {
    K_ILLEGAL, K_SET_CH, K_THRUST, K_CAL, K_ELAND, K_MOFF, K_WD_EN
  } cmd_kind_e;

  typedef struct packed {
    cmd_kind_e  kind;
    logic [3:0] ch;
  } cmd_dec_t;

  function automatic cmd_dec_t decode_cmd(input logic [7:0] op, input logic [4:0] num_sp);
    cmd_dec_t d;
    d.kind = K_ILLEGAL;
    d.ch   = 4'd0;
    if (op >= OP_SET_CH0 && op <= OP_SET_CH2) begin
      d.kind = K_SET_CH;
      d.ch   = op[3:0] - OP_SET_CH0[3:0];
    end else if (op[7:4] == OP_CH_NIB) begin
      d.kind = K_SET_CH;
      d.ch   = op[3:0];
    end else begin
      case (op)
        OP_THRUST: d.kind = K_THRUST;
        OP_CAL:    d.kind = K_CAL;
        OP_ELAND:  d.kind = K_ELAND;
        OP_MOFF:   d.kind = K_MOFF;
        OP_WD_EN:  d.kind = K_WD_EN;
        default:   d.kind = K_ILLEGAL;
      endcase
    end
    // A channel beyond the configured setpoint count is rejected like an unknown opcode.
    if (d.kind == K_SET_CH && {1'b0, d.ch} >= num_sp) d.kind = K_ILLEGAL;
    return d;
  endfunction

endpackage

// File: rtl/cfg_timer.sv
// Saturating up-counter with synchronous clear-to-zero load; done stays high
// once TERMINAL is reached until the next load.
module cfg_timer #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == WIDTH'(TERMINAL));

  always_comb begin
    cnt_d = cnt_q;
    if (load)             cnt_d = '0;
    else if (en && !done) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/flight_cmd_cfg.sv
// Flight command decoder: applies host setpoint/thrust/mode commands, sequences
// the IMU calibration handshake and lands the craft when the command stream goes silent.
module flight_cmd_cfg
  import flight_cmd_pkg::*;
#(
  parameter int NUM_SP     = 3,
  parameter int THRST_W    = 9,
  parameter int SPINUP_CYC = 2**27,
  parameter int CAL_TO_CYC = 2**26,
  parameter int WD_CYC     = 2**26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_rdy,
  input  logic [7:0]           cmd,
  input  logic [15:0]          data,
  output logic                 clr_cmd_rdy,
  output logic [7:0]           resp,
  output logic                 send_resp,
  output logic [NUM_SP*16-1:0] sp,
  output logic [THRST_W-1:0]   thrst,
  output logic                 strt_cal,
  output logic                 inertial_cal,
  input  logic                 cal_done,
  output logic                 motors_off,
  output logic                 wd_trip
);

  localparam int SPIN_W = $clog2(SPINUP_CYC + 1);
  localparam int CAL_W  = $clog2(CAL_TO_CYC + 1);
  localparam int WD_W   = $clog2(WD_CYC + 1);

  state_e                state_q, state_d;
  cmd_kind_e             kind_q, kind_d;
  logic [7:0]            resp_q, resp_d;
  logic [NUM_SP*16-1:0]  sp_q, sp_d;
  logic [THRST_W-1:0]    thrst_q, thrst_d;
  logic                  motors_off_q, motors_off_d;
  logic                  wd_trip_q, wd_trip_d;
  logic                  wd_en_q, wd_en_d;

  cmd_dec_t dec;
  logic consume, wd_run, wd_expire, cal_ok, cal_fail;
  logic spin_done, cal_to_done, wd_done;

  assign dec       = decode_cmd(cmd, 5'(NUM_SP));
  assign consume   = (state_q == ST_IDLE) && cmd_rdy;
  assign wd_run    = wd_en_q && !motors_off_q && (state_q inside {ST_IDLE, ST_EXEC, ST_RESP});
  // A command consumed in the expiry cycle counts as fresh traffic, so no trip.
  assign wd_expire = wd_run && wd_done && !consume;
  assign cal_ok    = (state_q == ST_CAL) && cal_done;
  assign cal_fail  = (state_q == ST_CAL) && !cal_done && cal_to_done;

  cfg_timer #(.WIDTH(SPIN_W), .TERMINAL(SPINUP_CYC - 1)) u_spin_tmr (
    .clk(clk), .rst(rst), .load(state_q != ST_SPINUP), .en(state_q == ST_SPINUP),
    .done(spin_done));

  cfg_timer #(.WIDTH(CAL_W), .TERMINAL(CAL_TO_CYC - 1)) u_cal_tmr (
    .clk(clk), .rst(rst), .load(state_q != ST_CAL), .en(state_q == ST_CAL),
    .done(cal_to_done));

  cfg_timer #(.WIDTH(WD_W), .TERMINAL(WD_CYC - 1)) u_wd_tmr (
    .clk(clk), .rst(rst), .load(consume || wd_expire || !wd_en_q), .en(wd_run),
    .done(wd_done));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_rdy) state_d = ST_EXEC;
      ST_EXEC:   state_d = (kind_q == K_CAL) ? ST_SPINUP : ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      ST_SPINUP: if (spin_done) state_d = ST_CAL;
      ST_CAL:    if (cal_ok || cal_fail) state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_cmd_rdy  = (state_q == ST_EXEC);
    send_resp    = (state_q == ST_RESP);
    inertial_cal = (state_q == ST_SPINUP) || (state_q == ST_CAL);
    strt_cal     = (state_q == ST_SPINUP) && spin_done;
  end

  always_comb begin
    kind_d       = kind_q;
    resp_d       = resp_q;
    sp_d         = sp_q;
    thrst_d      = thrst_q;
    motors_off_d = motors_off_q;
    wd_trip_d    = wd_trip_q;
    wd_en_d      = wd_en_q;
    if (consume) begin
      kind_d = dec.kind;
      if (dec.kind != K_ILLEGAL) wd_trip_d = 1'b0;
      if (dec.kind != K_CAL) resp_d = (dec.kind == K_ILLEGAL) ? RESP_NAK : RESP_ACK;
      case (dec.kind)
        K_SET_CH: begin
          for (int n = 0; n < NUM_SP; n++) begin
            if (dec.ch == 4'(n)) sp_d[16*n +: 16] = data;
          end
        end
        K_THRUST: thrst_d = data[THRST_W-1:0];
        K_CAL:    motors_off_d = 1'b0;
        K_ELAND: begin
          sp_d    = '0;
          thrst_d = '0;
        end
        K_MOFF:   motors_off_d = 1'b1;
        K_WD_EN:  wd_en_d = data[0];
        default:  ;
      endcase
    end else if (wd_expire) begin
      sp_d      = '0;
      thrst_d   = '0;
      wd_trip_d = 1'b1;
    end
    if (cal_ok) resp_d = RESP_ACK;
    if (cal_fail) begin
      resp_d       = RESP_NAK;
      motors_off_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q       <= K_ILLEGAL;
      resp_q       <= 8'h00;
      sp_q         <= '0;
      thrst_q      <= '0;
      motors_off_q <= 1'b1;
      wd_trip_q    <= 1'b0;
      wd_en_q      <= 1'b0;
    end else begin
      kind_q       <= kind_d;
      resp_q       <= resp_d;
      sp_q         <= sp_d;
      thrst_q      <= thrst_d;
      motors_off_q <= motors_off_d;
      wd_trip_q    <= wd_trip_d;
      wd_en_q      <= wd_en_d;
    end
  end

  assign resp       = resp_q;
  assign sp         = sp_q;
  assign thrst      = thrst_q;
  assign motors_off = motors_off_q;
  assign wd_trip    = wd_trip_q;

endmodule
